// File: rtl/pixel_feeder.sv
// pixel_feeder: buffers one host frame, replays it to the classifier core as a
// gap-free burst, then holds the returned digit until the host accepts it.

`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

module pixel_feeder #(
  parameter int DATA_WIDTH     = `DATA_WIDTH,
  parameter int NUM_PIXELS     = 784,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  i_valid,
  output logic [DATA_WIDTH-1:0] pixel,
  input  logic                  o_valid,
  input  logic [3:0]            digit,
  output logic                  res_valid,
  output logic [3:0]            res_digit,
  input  logic                  res_ready,
  output logic                  err,
  output logic [15:0]           frames_done
);

  // Address width for the buffer, count width able to hold NUM_PIXELS itself.
  localparam int AW = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1;
  localparam int CW = $clog2(NUM_PIXELS + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [CW-1:0] LAST_IDX   = CW'(NUM_PIXELS - 1);
  localparam logic [CW-1:0] END_IDX    = CW'(NUM_PIXELS);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    LOAD,
    STREAM,
    WAIT,
    RESULT
  } state_t;

  state_t                state;
  logic [CW-1:0]         wr_cnt;
  logic [CW-1:0]         rd_cnt;
  logic [TW-1:0]         timer;
  logic [DATA_WIDTH-1:0] frame_buf [NUM_PIXELS];

  logic                  load_fire;
  logic                  last_load;
  logic [DATA_WIDTH-1:0] first_pixel;

  assign load_fire = (state == LOAD) && s_valid && s_ready;
  assign last_load = load_fire && (wr_cnt == LAST_IDX);

  // Pixel 0 is launched on the same edge that writes the final pixel; for a
  // one-pixel frame those are the same location, so take it straight from s_data.
  assign first_pixel = (NUM_PIXELS == 1) ? s_data : frame_buf[0];

  // Frame buffer write port: one pixel per accepted host beat.
  // NOTE: the buffer has no reset; every location is rewritten by a complete
  // frame before it is ever streamed, and leaving it unreset keeps it a RAM.
  always_ff @(posedge clk) begin
    if (load_fire) begin
      frame_buf[wr_cnt[AW-1:0]] <= s_data;
    end
  end

  // Control FSM with all host- and core-facing outputs registered.
  // NOTE: every state register here uses <= so all of them update from the
  // same pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= LOAD;
      wr_cnt      <= '0;
      rd_cnt      <= '0;
      timer       <= '0;
      s_ready     <= 1'b0;
      i_valid     <= 1'b0;
      pixel       <= '0;
      res_valid   <= 1'b0;
      res_digit   <= '0;
      err         <= 1'b0;
      frames_done <= '0;
    end else begin
      case (state)
        LOAD: begin
          s_ready <= 1'b1;
          if (last_load) begin
            state   <= STREAM;
            s_ready <= 1'b0;
            wr_cnt  <= '0;
            i_valid <= 1'b1;
            pixel   <= first_pixel;
            rd_cnt  <= CW'(1);
          end else if (load_fire) begin
            wr_cnt <= wr_cnt + 1'b1;
          end
        end

        STREAM: begin
          if (rd_cnt == END_IDX) begin
            state   <= WAIT;
            i_valid <= 1'b0;
            pixel   <= '0;
            rd_cnt  <= '0;
            timer   <= '0;
          end else begin
            pixel  <= frame_buf[rd_cnt[AW-1:0]];
            rd_cnt <= rd_cnt + 1'b1;
          end
        end

        // The timeout wins over an o_valid arriving in the very cycle it fires,
        // so err is visible exactly TIMEOUT_CYCLES cycles after WAIT entry.
        WAIT: begin
          if (timer == TIMER_LAST) begin
            err     <= 1'b1;
            timer   <= '0;
            state   <= LOAD;
            s_ready <= 1'b1;
          end else if (o_valid) begin
            res_digit <= digit;
            res_valid <= 1'b1;
            timer     <= '0;
            state     <= RESULT;
          end else begin
            timer <= timer + 1'b1;
          end
        end

        RESULT: begin
          if (res_valid && res_ready) begin
            res_valid   <= 1'b0;
            frames_done <= frames_done + 1'b1;
            state       <= LOAD;
            s_ready     <= 1'b1;
          end
        end

        default: state <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_pixel_feeder.sv
// tb_pixel_feeder: directed frame-level scenarios with a pixel scoreboard that
// is filled as host beats are accepted and drained as the core sees pixels.

module tb_pixel_feeder;

  localparam int DW   = 8;
  localparam int NPIX = 784;
  localparam int TMO  = 4096;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [DW-1:0] s_data = '0;
  logic          i_valid;
  logic [DW-1:0] pixel;
  logic          o_valid = 1'b0;
  logic [3:0]    digit = '0;
  logic          res_valid;
  logic [3:0]    res_digit;
  logic          res_ready = 1'b0;
  logic          err;
  logic [15:0]   frames_done;

  always #5 clk = ~clk;

  pixel_feeder #(
    .DATA_WIDTH    (DW),
    .NUM_PIXELS    (NPIX),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .i_valid    (i_valid),
    .pixel      (pixel),
    .o_valid    (o_valid),
    .digit      (digit),
    .res_valid  (res_valid),
    .res_digit  (res_digit),
    .res_ready  (res_ready),
    .err        (err),
    .frames_done(frames_done)
  );

  int            total = 0;
  int            bad   = 0;
  logic [DW-1:0] pix_q[$];
  logic [3:0]    res_q[$];
  logic [15:0]   exp_frames = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Core-side monitor: every i_valid beat must match the next accepted host
  // pixel, and each uninterrupted burst must be exactly one frame long.
  int   stream_len = 0;
  logic prev_iv    = 1'b0;
  always @(posedge clk) begin
    #1;
    if (i_valid) begin
      if (pix_q.size() == 0) check("unexpected_ivalid", 32'(i_valid), 0);
      else check("pixel", 32'(pixel), 32'(pix_q.pop_front()));
      stream_len++;
    end else begin
      if (prev_iv && !rst) check("stream_len", stream_len, NPIX);
      stream_len = 0;
    end
    prev_iv = i_valid;
  end

  // Host side: push pixels (offset+i) with optional valid gaps and optional
  // spurious o_valid pulses from the core while loading.
  // NOTE: inputs are driven with blocking assignments at the falling edge,
  // half a cycle clear of the edge where the DUT samples them.
  task automatic send_frame(input int offset, input int gap, input bit spur);
    int i = 0;
    int cyc = 0;
    bit iv_seen = 1'b0;
    while (i < NPIX && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      if (i_valid) iv_seen = 1'b1;
      o_valid = spur && (cyc % 61 == 5);
      digit   = 4'd9;
      if (gap > 0 && $urandom_range(99) < gap) begin
        s_valid = 1'b0;
      end else begin
        s_valid = 1'b1;
        s_data  = DW'(i + offset);
        if (s_ready) begin
          pix_q.push_back(s_data);
          i++;
        end
      end
    end
    check("load_done", i, NPIX);
    check("no_ivalid_in_load", 32'(iv_seen), 0);
    @(negedge clk);
    check("s_ready_low_in_stream", 32'(s_ready), 0);
    s_valid = 1'b0;
    o_valid = 1'b0;
  endtask

  // Follow the burst until i_valid drops; on return we are in the first WAIT cycle.
  task automatic wait_stream(input bit spur);
    int k = 0;
    bit seen = 1'b0;
    while (k < 3000) begin
      @(negedge clk);
      k++;
      if (i_valid) seen = 1'b1;
      else if (seen) break;
      o_valid = spur && (k % 50 == 7);
      digit   = 4'd9;
    end
    o_valid = 1'b0;
    check("stream_end", 32'(seen && !i_valid), 1);
    check("no_result_before_core", 32'(res_valid), 0);
  endtask

  // Core model: one-cycle o_valid pulse after a delay.
  task automatic respond(input logic [3:0] d, input int delay);
    repeat (delay) @(negedge clk);
    o_valid = 1'b1;
    digit   = d;
    res_q.push_back(d);
    @(negedge clk);
    o_valid = 1'b0;
    digit   = 4'd0;
  endtask

  // Wait for the result, hold it for 'hold' cycles, then accept it.
  task automatic take_result(input int hold);
    int k = 0;
    logic [3:0] d;
    while (!res_valid && k < 100) begin
      @(negedge clk);
      k++;
    end
    d = (res_q.size() > 0) ? res_q.pop_front() : 4'hx;
    check("res_valid", 32'(res_valid), 1);
    check("res_digit", 32'(res_digit), 32'(d));
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("res_valid_held", 32'(res_valid), 1);
      check("res_digit_held", 32'(res_digit), 32'(d));
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready  = 1'b0;
    exp_frames = exp_frames + 16'd1;
    check("res_valid_cleared", 32'(res_valid), 0);
    check("frames_done", 32'(frames_done), 32'(exp_frames));
    check("s_ready_back", 32'(s_ready), 1);
  endtask

  initial begin
    int k;
    bit res_seen;

    // Reset sequence.
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_s_ready", 32'(s_ready), 0);
    check("rst_i_valid", 32'(i_valid), 0);
    check("rst_pixel", 32'(pixel), 0);
    check("rst_res_valid", 32'(res_valid), 0);
    check("rst_res_digit", 32'(res_digit), 0);
    check("rst_err", 32'(err), 0);
    check("rst_frames_done", 32'(frames_done), 0);
    rst = 1'b0;
    @(negedge clk);
    check("s_ready_after_rst", 32'(s_ready), 1);

    // Single frame, continuous pixels i mod 256, digit 7.
    send_frame(0, 0, 1'b0);
    wait_stream(1'b0);
    respond(4'd7, 0);
    take_result(0);

    // Host gaps during load, result back-pressured 50 cycles, digit 12 passes through.
    send_frame(17, 30, 1'b0);
    wait_stream(1'b0);
    respond(4'd12, 3);
    take_result(50);

    // Spurious o_valid during LOAD and STREAM, then a real digit 3.
    send_frame(200, 0, 1'b1);
    wait_stream(1'b1);
    respond(4'd3, 5);
    take_result(2);

    // Timeout: core silent; an o_valid in the firing cycle must be ignored.
    send_frame(5, 0, 1'b0);
    wait_stream(1'b0);
    res_seen = 1'b0;
    k = 0;
    while (k < TMO + 10) begin
      @(negedge clk);
      k++;
      if (res_valid) res_seen = 1'b1;
      if (err) break;
      o_valid = (k == TMO - 1);
      digit   = 4'd5;
    end
    o_valid = 1'b0;
    check("timeout_cycles", k, TMO);
    check("err_set", 32'(err), 1);
    check("s_ready_after_timeout", 32'(s_ready), 1);
    @(negedge clk);
    if (res_valid) res_seen = 1'b1;
    check("no_result_on_timeout", 32'(res_seen), 0);

    // Next frame still classifies; err is sticky.
    send_frame(90, 0, 1'b0);
    wait_stream(1'b0);
    respond(4'd1, 0);
    take_result(0);
    check("err_sticky", 32'(err), 1);

    // Reset around pixel 400 of the stream.
    send_frame(33, 0, 1'b0);
    k = 0;
    while (k < 400) begin
      @(negedge clk);
      if (i_valid) k++;
      else break;
    end
    check("reached_pixel_400", k, 400);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_i_valid", 32'(i_valid), 0);
    check("mid_rst_s_ready", 32'(s_ready), 0);
    check("mid_rst_err", 32'(err), 0);
    check("mid_rst_frames_done", 32'(frames_done), 0);
    rst = 1'b0;
    pix_q.delete();
    exp_frames = '0;
    res_seen   = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (i_valid) res_seen = 1'b1;
    end
    check("no_ivalid_after_rst", 32'(res_seen), 0);

    // A fresh full frame is required; no stale pixels may appear.
    send_frame(150, 10, 1'b0);
    wait_stream(1'b0);
    respond(4'd3, 0);
    take_result(0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/pixel_feeder.md
Name: pixel_feeder

Overview:
- Upstream stage of the MNIST accelerator core.
- Accepts one image's pixels from a host-side valid/ready stream and buffers the full frame on-chip.
- Replays the frame to the core as a gap-free burst on the core's i_valid/pixel inputs.
- Waits for the core's o_valid/digit, then holds the classified digit for the host until it is acknowledged. One frame in flight at a time.

Parameters:
- DATA_WIDTH, default `DATA_WIDTH (8): pixel width, identical to the core's pixel port.
- NUM_PIXELS, default 784: pixels per frame (28x28).
- TIMEOUT_CYCLES, default 4096: maximum cycles allowed in WAIT before the frame is abandoned.

Ports:
- clk  input  1  system clock, all logic on posedge.
- rst  input  1  synchronous, active-high reset (shared with the core).
- s_valid  input  1  host pixel valid.
- s_ready  output  1  feeder can accept a host pixel.
- s_data  input  DATA_WIDTH  host pixel value.
- i_valid  output  1  to core: pixel valid.
- pixel  output  DATA_WIDTH  to core: pixel value.
- o_valid  input  1  from core: digit valid (single-cycle pulse).
- digit  input  4  from core: classified digit.
- res_valid  output  1  result available to host.
- res_digit  output  4  captured digit.
- res_ready  input  1  host accepts result.
- err  output  1  sticky timeout flag.
- frames_done  output  16  count of results accepted by host; wraps at 2^16.

Behaviour:
- Reset (rst=1 at posedge): state=LOAD, wr_cnt=0, rd_cnt=0, timer=0.
- Outputs during reset: s_ready=0, i_valid=0, pixel=0, res_valid=0, res_digit=0, err=0, frames_done=0.
- s_ready rises the first cycle after rst deasserts.
- Reset mid-frame discards all buffered pixels and any pending result.
- All outputs are registered. Frame buffer is NUM_PIXELS x DATA_WIDTH, single write port, single read port.
- LOAD:
  - s_ready=1.
  - Each cycle with s_valid&&s_ready writes s_data to buf[wr_cnt] and increments wr_cnt.
  - The handshake with wr_cnt==NUM_PIXELS-1 moves the state to STREAM; s_ready=0 from the next cycle.
  - wr_cnt then clears to 0.
  - s_valid while s_ready=0 is ignored; the host must hold it.
- STREAM:
  - Let T be the cycle of the last LOAD handshake.
  - i_valid=1 with pixel=buf[k] in cycle T+1+k, for k=0..NUM_PIXELS-1.
  - Exactly NUM_PIXELS consecutive cycles, no bubbles, pixels in arrival order.
  - Cycle T+1+NUM_PIXELS: i_valid=0, pixel=0, state moves to WAIT.
- WAIT:
  - i_valid=0. timer increments every cycle.
  - On o_valid=1: res_digit<=digit, res_valid<=1 next cycle, state moves to RESULT, timer clears.
  - If timer reaches TIMEOUT_CYCLES with no o_valid: err<=1 (sticky until rst), no result produced, state moves to LOAD, timer clears.
- RESULT:
  - res_valid and res_digit held stable until res_valid&&res_ready.
  - On that handshake: res_valid=0 next cycle, frames_done+1 (0xFFFF wraps to 0x0000), state moves to LOAD.
- o_valid in any state other than WAIT is ignored: no capture, no state change. This includes an o_valid in the same cycle the timeout fires.
- digit is passed through unmodified; values 10–15 are not filtered.
- Throughput: host pixels are not accepted during STREAM, WAIT or RESULT.

Test Plan:
- Reset sequence: rst high 3 cycles -> all outputs 0; s_ready=1 in the first cycle after rst falls.
- Single frame: host sends pixels p[i]=i mod 256 with continuous s_valid -> 784 consecutive i_valid cycles with pixel=0,1,…,255,0,…; the core model pulses o_valid with digit=7 -> res_valid=1, res_digit=7; res_ready pulse -> frames_done=1, s_ready=1.
- Backpressure and gaps: random s_valid gaps during LOAD, and res_ready held low 50 cycles -> stream still gap-free and correctly ordered; res_digit stable throughout; exactly one frames_done increment.
- Timeout: core model never responds -> err=1 exactly TIMEOUT_CYCLES cycles after WAIT entry, res_valid stays 0, state returns to LOAD; a next frame still classifies and err stays 1.
- Spurious o_valid: o_valid pulses during LOAD and STREAM -> no res_valid, no corruption; a later correct o_valid (digit=3) yields res_digit=3.
- Reset mid-operation: rst asserted at pixel 400 of STREAM -> i_valid=0 the next cycle; a fresh 784-pixel frame is required before any i_valid; no stale pixels appear.
